// File: rtl/execute_stage_if.sv
// Execute stage port bundle: decode-side operands and control in,
// registered EX/MEM bundle and stall request out.
interface execute_stage_if;
    logic        keep;
    logic        nop;
    logic [4:0]  ALUOp_pype1;
    logic        ALUSrc_pype1;
    logic [31:0] read_data1_pype1;
    logic [31:0] read_data2_pype1;
    logic [31:0] imm_pype1;
    logic [31:0] PC_pype1;
    logic [31:0] Instraction_pype1;
    logic        RegWrite_pype1;
    logic [2:0]  MemBranch_pype1;
    logic [1:0]  MemtoReg_pype1;
    logic [1:0]  MemRW_pype1;
    logic [4:0]  WReg_pype1;

    logic        RegWrite_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [1:0]  MemtoReg_pype2;
    logic [1:0]  MemRW_pype2;
    logic [4:0]  WReg_pype2;
    logic [31:0] ALU_co_pype;
    logic [31:0] PCBranch_pype2;
    logic [31:0] PCp4_pype2;
    logic [31:0] read_data2_pype2;
    logic [31:0] Instraction_pype2;
    logic        ex_stall;

    modport master (
        output keep, nop, ALUOp_pype1, ALUSrc_pype1,
        output read_data1_pype1, read_data2_pype1, imm_pype1,
        output PC_pype1, Instraction_pype1,
        output RegWrite_pype1, MemBranch_pype1, MemtoReg_pype1,
        output MemRW_pype1, WReg_pype1,
        input  RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2,
        input  MemRW_pype2, WReg_pype2, ALU_co_pype,
        input  PCBranch_pype2, PCp4_pype2, read_data2_pype2,
        input  Instraction_pype2, ex_stall
    );

    modport slave (
        input  keep, nop, ALUOp_pype1, ALUSrc_pype1,
        input  read_data1_pype1, read_data2_pype1, imm_pype1,
        input  PC_pype1, Instraction_pype1,
        input  RegWrite_pype1, MemBranch_pype1, MemtoReg_pype1,
        input  MemRW_pype1, WReg_pype1,
        output RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2,
        output MemRW_pype2, WReg_pype2, ALU_co_pype,
        output PCBranch_pype2, PCp4_pype2, read_data2_pype2,
        output Instraction_pype2, ex_stall
    );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU and multiplier, multi-cycle
// restoring divider that stalls upstream while it iterates.
`ifndef MEMB_JALR
`define MEMB_JALR 3'd2
`endif

module execute_stage (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave bus
);
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem_r;
    logic [31:0] dvs;
    logic        lat_rem;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] alu_res;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    logic        is_div;
    logic        div_signed;
    logic        div_is_rem;
    logic        div_zero;
    logic        div_ovf;
    logic        div_special;
    logic        div_start;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] spec_res;
    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] fin_q;
    logic [31:0] fin_r;
    logic [31:0] div_res;
    logic [31:0] ex_res;

    assign a  = bus.read_data1_pype1;
    assign b  = bus.ALUSrc_pype1 ? bus.imm_pype1 : bus.read_data2_pype1;
    assign op = bus.ALUOp_pype1;

    // Shared 64-bit multiplier; operand extension picks the signedness.
    always_comb begin
        ext_a = {{32{a[31]}}, a};
        ext_b = {{32{b[31]}}, b};
        if (op == OP_MULHU) begin
            ext_a = {32'd0, a};
        end
        if (op == OP_MULHU || op == OP_MULHSU) begin
            ext_b = {32'd0, b};
        end
        prod = ext_a * ext_b;
    end

    // Single-cycle ALU and multiply result selection.
    always_comb begin
        alu_res = 32'd0;
        case (op)
            OP_ADD:    alu_res = a + b;
            OP_SUB:    alu_res = a - b;
            OP_SLL:    alu_res = a << b[4:0];
            OP_SLT:    alu_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:   alu_res = {31'd0, a < b};
            OP_XOR:    alu_res = a ^ b;
            OP_SRL:    alu_res = a >> b[4:0];
            OP_SRA:    alu_res = $signed(a) >>> b[4:0];
            OP_OR:     alu_res = a | b;
            OP_AND:    alu_res = a & b;
            OP_PASSB:  alu_res = b;
            OP_MUL:    alu_res = prod[31:0];
            OP_MULH:   alu_res = prod[63:32];
            OP_MULHSU: alu_res = prod[63:32];
            OP_MULHU:  alu_res = prod[63:32];
            default:   alu_res = 32'd0;
        endcase
    end

    assign is_div     = (op == OP_DIV) || (op == OP_DIVU) ||
                        (op == OP_REM) || (op == OP_REMU);
    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign div_is_rem = (op == OP_REM) || (op == OP_REMU);
    assign div_zero   = (b == 32'd0);
    assign div_ovf    = div_signed && (a == 32'h8000_0000) &&
                        (b == 32'hFFFF_FFFF);
    assign div_special = is_div && (div_zero || div_ovf);
    assign div_start   = is_div && !div_special;

    assign mag_a = (div_signed && a[31]) ? -a : a;
    assign mag_b = (div_signed && b[31]) ? -b : b;

    // Divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        spec_res = 32'd0;
        if (div_zero) begin
            spec_res = div_is_rem ? a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            spec_res = div_is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step: shift in the next dividend bit, try subtract.
    assign trial = {rem_r, quo[31]};
    assign diff  = trial - {1'b0, dvs};

    assign fin_q   = neg_q ? -quo : quo;
    assign fin_r   = neg_r ? -rem_r : rem_r;
    assign div_res = lat_rem ? fin_r : fin_q;

    // Result mux with JALR target alignment on bit 0.
    always_comb begin
        if (state == DONE) begin
            ex_res = div_res;
        end else if (div_special) begin
            ex_res = spec_res;
        end else begin
            ex_res = alu_res;
        end
        if (bus.MemBranch_pype1 == `MEMB_JALR) begin
            ex_res[0] = 1'b0;
        end
    end

    assign bus.ex_stall = ((state == IDLE) && div_start) || (state == BUSY);

    // Divider FSM: latch magnitudes, iterate 32 times, then one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            quo     <= 32'd0;
            rem_r   <= 32'd0;
            dvs     <= 32'd0;
            lat_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (bus.nop) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else if (!bus.keep) begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state   <= BUSY;
                        cnt     <= 5'd0;
                        quo     <= mag_a;
                        rem_r   <= 32'd0;
                        dvs     <= mag_b;
                        lat_rem <= div_is_rem;
                        neg_q   <= div_signed && (a[31] ^ b[31]);
                        neg_r   <= div_signed && a[31];
                    end
                end
                BUSY: begin
                    quo   <= {quo[30:0], !diff[32]};
                    rem_r <= diff[32] ? trial[31:0] : diff[31:0];
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output registers: bubble on nop or stall, hold on keep, else load.
    always_ff @(posedge clk) begin
        if (rst || bus.nop || (!bus.keep && bus.ex_stall)) begin
            bus.RegWrite_pype2    <= 1'b0;
            bus.MemBranch_pype2   <= 3'd0;
            bus.MemtoReg_pype2    <= 2'd0;
            bus.MemRW_pype2       <= 2'd0;
            bus.WReg_pype2        <= 5'd0;
            bus.ALU_co_pype       <= 32'd0;
            bus.PCBranch_pype2    <= 32'd0;
            bus.PCp4_pype2        <= 32'd0;
            bus.read_data2_pype2  <= 32'd0;
            bus.Instraction_pype2 <= 32'd0;
        end else if (!bus.keep) begin
            bus.RegWrite_pype2    <= bus.RegWrite_pype1;
            bus.MemBranch_pype2   <= bus.MemBranch_pype1;
            bus.MemtoReg_pype2    <= bus.MemtoReg_pype1;
            bus.MemRW_pype2       <= bus.MemRW_pype1;
            bus.WReg_pype2        <= bus.WReg_pype1;
            bus.ALU_co_pype       <= ex_res;
            bus.PCBranch_pype2    <= bus.PC_pype1 + bus.imm_pype1;
            bus.PCp4_pype2        <= bus.PC_pype1 + 32'd4;
            bus.read_data2_pype2  <= bus.read_data2_pype1;
            bus.Instraction_pype2 <= bus.Instraction_pype1;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed corner cases plus
// randomized operations checked against an arithmetic reference model.
`ifndef MEMB_JALR
`define MEMB_JALR 3'd2
`endif

module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    execute_stage_if bus();

    execute_stage dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic        src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rw;
        logic [2:0]  mb;
        logic [1:0]  mtr;
        logic [1:0]  mrw;
        logic [4:0]  wreg;
    } txn_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pcb;
        logic [31:0] pc4;
        logic [31:0] rd2;
        logic [31:0] instr;
        logic        rw;
        logic [2:0]  mb;
        logic [1:0]  mtr;
        logic [1:0]  mrw;
        logic [4:0]  wreg;
    } exp_t;

    int          checks = 0;
    int          fails = 0;
    int          tag = 0;
    exp_t        sb_q[$];
    logic [31:0] last_tag = 32'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        logic [4:0]      sh;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = b[4:0];
        r  = 32'd0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << sh;
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> sh;
            5'd7:  r = $signed(a) >>> sh;
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = b;
            5'd11: begin p = sa * sb; r = p[31:0]; end
            5'd12: begin p = sa * sb; r = p[63:32]; end
            5'd13: begin p = sa * longint'(ub); r = p[63:32]; end
            5'd14: begin p = longint'(ua * ub); r = p[63:32]; end
            5'd15: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = sa / sb; r = p[31:0]; end
            end
            5'd16: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: begin
                if (b == 0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            5'd18: r = (b == 0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] opnd_b(input txn_t t);
        return t.src ? t.imm : t.rd2;
    endfunction

    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.alu = ref_alu(t.op, t.rd1, opnd_b(t));
        if (t.mb == `MEMB_JALR) e.alu[0] = 1'b0;
        e.pcb   = t.pc + t.imm;
        e.pc4   = t.pc + 32'd4;
        e.rd2   = t.rd2;
        e.instr = t.instr;
        e.rw    = t.rw;
        e.mb    = t.mb;
        e.mtr   = t.mtr;
        e.mrw   = t.mrw;
        e.wreg  = t.wreg;
        return e;
    endfunction

    // Cycles of stall expected: long divides only, 33 cycles each.
    function automatic int model_stall(input txn_t t);
        logic [31:0] bb;
        bit          sgn;
        bb  = opnd_b(t);
        sgn = (t.op == 5'd15) || (t.op == 5'd17);
        if (t.op < 5'd15 || t.op > 5'd18) return 0;
        if (bb == 0) return 0;
        if (sgn && t.rd1 == 32'h8000_0000 && bb == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    function automatic txn_t mk(input int op, input logic [31:0] a,
                                input logic [31:0] b, input logic src,
                                input logic [31:0] pc, input logic [2:0] mb);
        txn_t t;
        t.op   = op[4:0];
        t.src  = src;
        t.rd1  = a;
        t.rd2  = src ? $urandom : b;
        t.imm  = src ? b : $urandom;
        t.pc   = pc;
        t.instr = 32'd0;
        t.rw   = 1'b1;
        t.mb   = mb;
        t.mtr  = 2'($urandom_range(0, 3));
        t.mrw  = 2'($urandom_range(0, 3));
        t.wreg = 5'($urandom_range(1, 31));
        return t;
    endfunction

    task automatic apply(input txn_t t);
        bus.ALUOp_pype1       = t.op;
        bus.ALUSrc_pype1      = t.src;
        bus.read_data1_pype1  = t.rd1;
        bus.read_data2_pype1  = t.rd2;
        bus.imm_pype1         = t.imm;
        bus.PC_pype1          = t.pc;
        bus.Instraction_pype1 = t.instr;
        bus.RegWrite_pype1    = t.rw;
        bus.MemBranch_pype1   = t.mb;
        bus.MemtoReg_pype1    = t.mtr;
        bus.MemRW_pype1       = t.mrw;
        bus.WReg_pype1        = t.wreg;
    endtask

    task automatic idle_inputs();
        txn_t t;
        t = mk(0, 32'd0, 32'd0, 1'b0, 32'd0, 3'd0);
        t.rw = 1'b0;
        t.rd2 = 32'd0;
        t.imm = 32'd0;
        apply(t);
    endtask

    // Present one instruction, hold it while stalled, optionally inject
    // keep (3 cycles), nop or rst at a given cycle offset.
    task automatic run(input txn_t t, input int keep_at,
                       input int nop_at, input int rst_at);
        int cyc;
        int stalls;
        int exp_st;
        exp_st = model_stall(t) + ((keep_at >= 0) ? 3 : 0);
        @(posedge clk);
        #1;
        tag++;
        t.instr = tag;
        apply(t);
        if (nop_at < 0 && rst_at < 0) sb_q.push_back(model(t));
        cyc = 0;
        stalls = 0;
        while (cyc < 200) begin
            bus.keep = (keep_at >= 0) && (cyc >= keep_at) &&
                       (cyc < keep_at + 3);
            bus.nop = (cyc == nop_at);
            rst = (cyc == rst_at);
            #1;
            if (bus.ex_stall) stalls++;
            if (bus.nop || rst) begin
                @(posedge clk);
                #1;
                bus.nop = 1'b0;
                rst = 1'b0;
                idle_inputs();
                #1;
                if (nop_at >= 0) begin
                    check("nop_bubble",
                          {bus.Instraction_pype2, bus.RegWrite_pype2,
                           bus.MemRW_pype2, bus.MemBranch_pype2,
                           bus.MemtoReg_pype2, bus.WReg_pype2}, 64'd0);
                end else begin
                    check("rst_outputs_zero",
                          {63'd0, |{bus.RegWrite_pype2, bus.MemBranch_pype2,
                           bus.MemtoReg_pype2, bus.MemRW_pype2,
                           bus.WReg_pype2, bus.ALU_co_pype,
                           bus.PCBranch_pype2, bus.PCp4_pype2,
                           bus.read_data2_pype2, bus.Instraction_pype2}},
                          64'd0);
                end
                check("stall_after_abort", {63'd0, bus.ex_stall}, 64'd0);
                return;
            end
            if (!bus.ex_stall && !bus.keep) break;
            if (cyc == 2) begin
                check("stall_bubble",
                      {bus.Instraction_pype2, bus.RegWrite_pype2,
                       bus.MemRW_pype2, bus.MemBranch_pype2,
                       bus.MemtoReg_pype2, bus.WReg_pype2}, 64'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stall_cycles", 64'(stalls), 64'(exp_st));
    endtask

    // Monitor: each newly presented instruction tag is matched in order.
    always @(negedge clk) begin
        if (!rst && bus.Instraction_pype2 != 32'd0 &&
            bus.Instraction_pype2 != last_tag) begin
            exp_t e;
            last_tag = bus.Instraction_pype2;
            if (sb_q.size() == 0) begin
                check("unexpected_output", {32'd0, bus.Instraction_pype2},
                      64'd0);
            end else begin
                e = sb_q.pop_front();
                check("tag", {32'd0, bus.Instraction_pype2},
                      {32'd0, e.instr});
                check("alu", {32'd0, bus.ALU_co_pype}, {32'd0, e.alu});
                check("pc_branch_p4",
                      {bus.PCBranch_pype2, bus.PCp4_pype2},
                      {e.pcb, e.pc4});
                check("pass_through",
                      {19'd0, bus.read_data2_pype2, bus.RegWrite_pype2,
                       bus.MemBranch_pype2, bus.MemtoReg_pype2,
                       bus.MemRW_pype2, bus.WReg_pype2},
                      {19'd0, e.rd2, e.rw, e.mb, e.mtr, e.mrw, e.wreg});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        t;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        bus.keep = 1'b0;
        bus.nop  = 1'b0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_outputs",
              {63'd0, |{bus.RegWrite_pype2, bus.MemBranch_pype2,
               bus.MemtoReg_pype2, bus.MemRW_pype2, bus.WReg_pype2,
               bus.ALU_co_pype, bus.PCBranch_pype2, bus.PCp4_pype2,
               bus.read_data2_pype2, bus.Instraction_pype2}}, 64'd0);
        check("reset_stall", {63'd0, bus.ex_stall}, 64'd0);

        run(mk(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'h100, 3'd0), -1, -1, -1);
        run(mk(15, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h200, 3'd0), -1, -1, -1);
        run(mk(17, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h204, 3'd0), -1, -1, -1);
        run(mk(16, 32'd5, 32'd0, 1'b0, 32'h208, 3'd0), -1, -1, -1);
        run(mk(18, 32'd5, 32'd0, 1'b0, 32'h20C, 3'd0), -1, -1, -1);
        run(mk(15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h210, 3'd0),
            -1, -1, -1);
        run(mk(17, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h214, 3'd0),
            -1, -1, -1);
        run(mk(16, 32'd1000, 32'd7, 1'b0, 32'h218, 3'd0), 5, -1, -1);
        run(mk(15, 32'd1234, 32'd5, 1'b0, 32'h21C, 3'd0), -1, 10, -1);
        run(mk(0, 32'd3, 32'd4, 1'b0, 32'h220, 3'd0), -1, -1, -1);
        run(mk(17, 32'd99, 32'd4, 1'b0, 32'h224, 3'd0), -1, -1, 5);
        run(mk(0, 32'd10, 32'd20, 1'b0, 32'h228, 3'd0), -1, -1, -1);
        run(mk(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h22C, 3'd0),
            -1, -1, -1);
        run(mk(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h230, 3'd0),
            -1, -1, -1);
        run(mk(0, 32'h1000, 32'd1, 1'b0, 32'h234, `MEMB_JALR), -1, -1, -1);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) op = 15 + $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 40));
                default: ;
            endcase
            t = mk(op, a, b, 1'($urandom_range(0, 1)), $urandom,
                   3'($urandom_range(0, 7)));
            t.rw = 1'($urandom_range(0, 1));
            run(t, -1, -1, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 keep  in  1  freeze: hold all output registers and divider state.
REQ-005 nop  in  1  load a bubble into the output registers and abort any divide.
REQ-006 ALUOp_pype1  in  5  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU; 19-31 give result 0.
REQ-007 ALUSrc_pype1  in  1  1 selects imm_pype1 as operand B, 0 selects read_data2_pype1.
REQ-008 read_data1_pype1, read_data2_pype1, imm_pype1, PC_pype1, Instraction_pype1  in  32 each  forwarded operands, immediate, PC, instruction.
REQ-009 RegWrite_pype1 in 1, MemBranch_pype1 in 3, MemtoReg_pype1 in 2, MemRW_pype1 in 2, WReg_pype1 in 5  control from decode.
REQ-010 Registered outputs: RegWrite_pype2 1, MemBranch_pype2 3, MemtoReg_pype2 2, MemRW_pype2 2, WReg_pype2 5, ALU_co_pype 32, PCBranch_pype2 32, PCp4_pype2 32, read_data2_pype2 32, Instraction_pype2 32.
REQ-011 ex_stall  out  1  combinational; high means upstream must hold its inputs.

Function
REQ-012 Normal op: each posedge with no rst/nop/keep/stall, outputs load the EX result; latency 1 cycle.
REQ-013 ALU_co_pype = op(A=read_data1, B); shifts use B[4:0]; SLT/SLTU give 32'd1/32'd0; MUL* take the low or high 32 bits of the 64-bit product with the signedness named by the opcode, single cycle.
REQ-014 PCBranch_pype2 = PC_pype1 + imm_pype1; PCp4_pype2 = PC_pype1 + 4; both mod 2^32.
REQ-015 When MemBranch_pype1 == `MEMB_JALR, ALU_co_pype bit 0 is forced to 0.
REQ-016 read_data2_pype2, WReg, RegWrite, MemtoReg, MemRW, MemBranch and Instraction pass through unchanged.
REQ-017 Divider FSM states: IDLE, BUSY, DONE; 5-bit iteration counter; restoring algorithm, one quotient bit per cycle on operand magnitudes; signs applied in DONE.
REQ-018 Special divides complete in 1 cycle without entering BUSY: divisor 0 gives quotient 32'hFFFFFFFF and remainder = dividend; signed 32'h80000000 / 32'hFFFFFFFF gives quotient 32'h80000000 and remainder 0.
REQ-019 IDLE->BUSY when a non-special DIV/DIVU/REM/REMU is presented; operands, op and signs are latched and the counter is cleared.
REQ-020 BUSY performs 32 iterations, then goes to DONE when the counter equals 31 at the posedge.
REQ-021 DONE lasts 1 cycle: outputs load the result plus the held control inputs, then the FSM returns to IDLE.
REQ-022 ex_stall = (IDLE and non-special divide presented) or BUSY; it is 0 in DONE.
REQ-023 Every posedge where ex_stall is 1 (and no keep), the outputs load a bubble: RegWrite, MemRW, MemBranch, MemtoReg, WReg and Instraction all 0.
REQ-024 Divide timing: presented in cycle T, ex_stall is high for T..T+32, DONE occurs at T+33, and the result is on the outputs from T+34.
REQ-025 Priority at each posedge: rst > nop > keep > divider/normal.
REQ-026 keep freezes the FSM, counter and all outputs; ex_stall holds its value.
REQ-027 nop during BUSY/DONE returns the FSM to IDLE and discards the result.

Reset
REQ-028 While rst is high at a posedge, all outputs become 0 and the FSM goes to IDLE with counter 0; ex_stall is 0 in the cycle after.
REQ-029 rst asserted mid-divide abandons the divide; no partial result ever appears on the outputs.

Verification
REQ-030 ADD with A=7, ALUSrc=1, imm=-3, PC=0x100 -> next cycle ALU_co=4, PCBranch=0xFD, PCp4=0x104.
REQ-031 DIV with A=-7, B=2 at cycle T -> ex_stall high T..T+32, bubbles on the outputs, ALU_co=0xFFFFFFFD with RegWrite=1 at T+34; REM with the same operands -> 0xFFFFFFFF.
REQ-032 DIVU with B=0, A=5 -> no stall, next cycle ALU_co=0xFFFFFFFF; REMU -> 5; DIV 0x80000000/-1 -> 0x80000000.
REQ-033 keep held for 3 cycles during BUSY -> completion delayed by exactly 3 cycles, result unchanged.
REQ-034 nop at T+10 of a divide -> bubble, ex_stall 0 the next cycle, FSM IDLE; rst at T+5 -> all outputs 0.
REQ-035 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same -> 0; JALR with ADD result 0x1001 -> ALU_co 0x1000.
